// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One operation in flight: accept in IDLE, drive the ALU in EXEC, hold the result in RESP.
module alu_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [2:0]      req0_op,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [2:0]      req1_op,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    output logic            resp0_valid,
    input  logic            resp0_ready,
    output logic [XLEN-1:0] resp0_data,
    output logic            resp0_err,
    output logic            resp1_valid,
    input  logic            resp1_ready,
    output logic [XLEN-1:0] resp1_data,
    output logic            resp1_err,
    output logic [2:0]      alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_out
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic            owner_q, owner_d;
    logic [2:0]      alu_op_q, alu_op_d;
    logic [XLEN-1:0] alu_a_q, alu_a_d;
    logic [XLEN-1:0] alu_b_q, alu_b_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            err_q, err_d;
    logic [1:0]      resp_valid_q, resp_valid_d;
    logic            idle;
    logic            unsupported;
    logic            owner_ready;

    // last_q names the requester granted last; a tie goes to the other one.
    assign idle        = (state_q == IDLE) && rst_n;
    assign req0_ready  = idle && req0_valid && (!req1_valid || last_q);
    assign req1_ready  = idle && req1_valid && (!req0_valid || !last_q);
    assign unsupported = alu_op_q inside {3'b011, 3'b100, 3'b101};
    assign owner_ready = owner_q ? resp1_ready : resp0_ready;

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        owner_d      = owner_q;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        data_d       = data_q;
        err_d        = err_q;
        resp_valid_d = resp_valid_q;
        case (state_q)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    owner_d  = req1_ready;
                    last_d   = req1_ready;
                    alu_op_d = req1_ready ? req1_op : req0_op;
                    alu_a_d  = req1_ready ? req1_a  : req0_a;
                    alu_b_d  = req1_ready ? req1_b  : req0_b;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                data_d       = unsupported ? '0 : alu_out;
                err_d        = unsupported;
                alu_op_d     = '0;
                alu_a_d      = '0;
                alu_b_d      = '0;
                resp_valid_d = owner_q ? 2'b10 : 2'b01;
                state_d      = RESP;
            end
            RESP: begin
                if (owner_ready) begin
                    resp_valid_d = '0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d      = IDLE;
                resp_valid_d = '0;
                alu_op_d     = '0;
                alu_a_d      = '0;
                alu_b_d      = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            owner_q      <= 1'b0;
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            owner_q      <= owner_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            data_q       <= data_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign alu_op      = alu_op_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign resp0_valid = resp_valid_q[0];
    assign resp1_valid = resp_valid_q[1];
    assign resp0_data  = data_q;
    assign resp1_data  = data_q;
    assign resp0_err   = err_q;
    assign resp1_err   = err_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: XLEN, 32, operand/result width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-005 req0_ready / req1_ready  output  1  arbiter accepts requester N this cycle.
REQ-006 req0_op / req1_op  input  3  ALU opcode: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  XLEN  operands.
REQ-008 resp0_valid / resp1_valid  output  1  result for requester N available.
REQ-009 resp0_ready / resp1_ready  input  1  requester N consumes its result.
REQ-010 resp0_data / resp1_data  output  XLEN  result.
REQ-011 resp0_err / resp1_err  output  1  opcode was unsupported (011, 100, 101).
REQ-012 alu_op  output  3  opcode driven to the shared ALU.
REQ-013 alu_a, alu_b  output  XLEN  operands driven to the shared ALU.
REQ-014 alu_out  input  XLEN  combinational ALU result.

Function
REQ-015 FSM states: IDLE, EXEC, RESP; one operation in flight at a time.
REQ-016 IDLE: reqN_ready = reqN_valid && granted(N); at most one ready high per cycle; all ready low outside IDLE.
REQ-017 Arbitration: round-robin; a lone valid requester is granted; if both are valid, the requester not granted last wins; the pointer updates only on acceptance.
REQ-018 Acceptance (valid && ready, cycle T): latch op, a, b and owner ID; next state EXEC.
REQ-019 EXEC (cycle T+1): alu_op/alu_a/alu_b = latched values; capture alu_out into the result register at end of cycle; next state RESP.
REQ-020 Unsupported opcode: in EXEC, result register loads 0 and err flag sets; alu_* still driven with latched values.
REQ-021 RESP (from T+2): respN_valid high for the owner only; respN_data/respN_err held stable until respN_ready.
REQ-022 respN_valid && respN_ready: next state IDLE; new acceptance possible the cycle after the handshake (min issue interval 3 cycles).
REQ-023 respN_ready while respN_valid is low has no effect; resp ready from the non-owner is ignored.
REQ-024 IDLE/RESP: alu_op/alu_a/alu_b = 0.
REQ-025 Request inputs are ignored outside IDLE; requesters hold valid/op/operands until ready (no drop checking required).
REQ-026 Result width: exactly XLEN bits; the arbiter does no arithmetic, results come only from alu_out.

Reset
REQ-027 rst_n low: state IDLE; all ready, resp_valid and resp_err = 0; resp_data = 0; alu_* = 0; RR pointer set so requester 0 wins the first tie.
REQ-028 Reset asserted mid-operation (EXEC or RESP): the in-flight operation is discarded, no response is ever issued, and outputs take reset values immediately.
REQ-029 First acceptance possible on the first rising edge after rst_n deasserts.

Verification
REQ-030 req0 AND a=2 b=3 alone -> req0_ready at T, alu_op=000 at T+1, resp0_valid T+2 with data=2, err=0.
REQ-031 req1 ops OR/ADD/SUB/SLT a=2 b=3 back-to-back -> data 3, 5, 0xFFFFFFFF, 1; resp0_valid never asserted.
REQ-032 Both valid after reset, continuously, with ready responses -> grants 0,1,0,1; each response routed to the correct owner.
REQ-033 resp0_ready held low 5 cycles in RESP -> resp0_valid/data stable; req1_valid high meanwhile, req1_ready stays 0 until the cycle after the handshake.
REQ-034 req0_op=100 -> resp0_valid, data=0, err=1; next op 010 with a=7 b=1 -> data=8, err=0.
REQ-035 rst_n low during EXEC of req1 -> no resp1_valid; after release, req1 ADD 1+1 returns 2.
